hilo_muldiv_unit: RTL and testbench

Parametrised HI/LO result register pair with an integrated iterative multiply/divide engine. It is the MIPS HI/LO block for the execute stage. It accepts MTHI/MTLO writes and signed or unsigned MULT/DIV commands. It holds the architectural HI/LO values stable while an operation is in flight and signals completion so the pipeline can stall MFHI/MFLO.

---
 rtl/hilo_pkg.sv | 30 +++
 rtl/hilo_iter_core.sv | 80 ++++++++
 rtl/hilo_muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit: command codes, FSM states
// and the signedness helper used at operand capture.
package hilo_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MTHI  = 4'd1,
    OP_MTLO  = 4'd2,
    OP_MULT  = 4'd3,
    OP_MULTU = 4'd4,
    OP_DIV   = 4'd5,
    OP_DIVU  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  function automatic logic is_signed(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// WIDTH-step unsigned datapath shared by shift-add multiply and restoring divide.
// hi/lo hold {product} while multiplying and {remainder, quotient} while dividing.
module hilo_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             div_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH:0]   mul_sum, div_pr, div_diff;

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_pr   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_pr - {1'b0, opnd_q};
    if (load_i) begin
      cnt_d  = '0;
      div_d  = div_i;
      hi_d   = '0;
      lo_d   = a_i;
      opnd_d = b_i;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        // Restore is implicit: keep the shifted partial remainder when the trial goes negative.
        if (div_pr >= {1'b0, opnd_q}) begin
          hi_d = div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_pr[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

  assign last_o = step_i && (cnt_q == CW'(WIDTH - 1));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// MIPS HI/LO register pair with iterative MULT/DIV; HI/LO change only on MTHI/MTLO
// or the FIX->IDLE edge. Define HILO_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t           state_q;
  op_t              op_q, op_in;
  logic             neg_q, rneg_q, bzero_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] a_q, hi_q, lo_q;
  logic [WIDTH-1:0] fix_hi_d, fix_lo_d;
  logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo;
  logic [2*WIDTH-1:0] prod;
  logic             a_neg, b_neg, start_mul, start_div, core_last;

  always_comb begin
    op_in     = op_t'(Op);
    a_neg     = is_signed(op_in) & A[WIDTH-1];
    b_neg     = is_signed(op_in) & B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    start_mul = 1'b0;
    start_div = 1'b0;
    if (Start && !Clr && state_q == ST_IDLE) begin
      case (op_in)
        OP_MULT, OP_MULTU: start_mul = 1'b1;
`ifdef HILO_MADD_EN
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: start_mul = 1'b1;
`endif
        OP_DIV, OP_DIVU:   start_div = 1'b1;
        default: ;
      endcase
    end
  end

  hilo_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .load_i (start_mul | start_div),
    .div_i  (start_div),
    .step_i (state_q == ST_MUL || state_q == ST_DIV),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .last_o (core_last),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  // Sign fix-up and accumulate, evaluated from the magnitude result during FIX.
  always_comb begin
    prod = {core_hi, core_lo};
    if (neg_q) prod = -prod;
    {fix_hi_d, fix_lo_d} = prod;
`ifdef HILO_MADD_EN
    if (op_q == OP_MADD || op_q == OP_MADDU) {fix_hi_d, fix_lo_d} = {hi_q, lo_q} + prod;
    if (op_q == OP_MSUB || op_q == OP_MSUBU) {fix_hi_d, fix_lo_d} = {hi_q, lo_q} - prod;
`endif
    if (op_q == OP_DIV || op_q == OP_DIVU) begin
      if (bzero_q) begin
        fix_hi_d = a_q;
        fix_lo_d = '1;
      end else begin
        fix_hi_d = rneg_q ? -core_hi : core_hi;
        fix_lo_d = neg_q ? -core_lo : core_lo;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      if (Clr) begin
        state_q <= ST_IDLE;
        hi_q    <= '0;
        lo_q    <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_mul || start_div) begin
              state_q <= start_div ? ST_DIV : ST_MUL;
              busy_q  <= 1'b1;
              op_q    <= op_in;
              a_q     <= A;
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              bzero_q <= start_div && (B == '0);
            end else if (Start && op_in == OP_MTHI) begin
              hi_q <= A;
            end else if (Start && op_in == OP_MTLO) begin
              lo_q <= A;
            end
          end
          ST_MUL, ST_DIV: if (core_last) state_q <= ST_FIX;
          ST_FIX: begin
            state_q <= ST_IDLE;
            hi_q    <= fix_hi_d;
            lo_q    <= fix_lo_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dz_q    <= bzero_q;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: vector table of MULT/DIV results plus
// hand-written control sequences (ignored Start, Clr abort, async reset, MTHI/MTLO, MADD).
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0, Rst = 1'b1, Clr = 1'b0, Start = 1'b0;
  logic [3:0]   Op = 4'd0;
  logic [W-1:0] A = '0, B = '0;
  logic         Busy, Done, DivZero;
  logic [W-1:0] HI, LO;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    op_t          op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } vec_t;

  vec_t tbl[13];

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one MULT/DIV-class op; optionally pulse a competing MULT Start at loop step inj.
  task automatic do_vec(input string tag, input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi_e, input logic [W-1:0] lo_e, input logic dz_e, input int inj);
    logic [W-1:0] hi0, lo0;
    logic hold_bad;
    int busy_n;
    hi0 = HI;
    lo0 = LO;
    hold_bad = 1'b0;
    busy_n = 0;
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    for (int i = 0; i < 200; i++) begin
      if (Done) break;
      if (Busy) busy_n++;
      if (HI !== hi0 || LO !== lo0) hold_bad = 1'b1;
      if (i == inj) begin
        Start = 1'b1; Op = OP_MULT; A = '1; B = '1;
      end
      tick();
      Start = 1'b0;
    end
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h done=%b dz=%b busy_cycles=%0d",
             tag, op, a, b, HI, LO, Done, DivZero, busy_n);
    chk({tag, ".busy_cycles"}, W'(busy_n), W'(W + 1));
    chk({tag, ".done"}, W'(Done), W'(1));
    chk({tag, ".divzero"}, W'(DivZero), W'(dz_e));
    chk({tag, ".hi"}, HI, hi_e);
    chk({tag, ".lo"}, LO, lo_e);
    chk({tag, ".hold"}, W'(hold_bad), W'(0));
  endtask

  initial begin
    logic done_seen;

    tbl[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[4]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    tbl[5]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    tbl[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tbl[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[8]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    tbl[9]  = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
    tbl[10] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    tbl[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    tbl[12] = '{OP_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};

    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    chk("reset.hi", HI, '0);
    chk("reset.lo", LO, '0);
    chk("reset.busy", W'(Busy), W'(0));
    chk("reset.done", W'(Done), W'(0));
    chk("reset.divzero", W'(DivZero), W'(0));

    // Each op after the first is issued in the cycle the previous Done is high.
    for (int i = 0; i < 13; i++)
      do_vec($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz, -1);

    do_vec("ignore_start", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 5);

    Op = OP_MULTU; A = 32'd9; B = 32'd9; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (5) tick();
    #2 Rst = 1'b1;
    #1;
    $display("async_rst mid-MUL -> hi=%h lo=%h busy=%b done=%b dz=%b", HI, LO, Busy, Done, DivZero);
    chk("async_rst.hi", HI, '0);
    chk("async_rst.lo", LO, '0);
    chk("async_rst.busy", W'(Busy), W'(0));
    chk("async_rst.done", W'(Done), W'(0));
    chk("async_rst.divzero", W'(DivZero), W'(0));
    #1 Rst = 1'b0;
    tick();
    chk("async_rst.idle", W'(Busy), W'(0));

    Op = OP_MTHI; A = 32'h12345678; Start = 1'b1;
    tick();
    Start = 1'b0;
    $display("mthi a=12345678 -> hi=%h busy=%b", HI, Busy);
    chk("mthi.hi", HI, 32'h12345678);
    chk("mthi.busy", W'(Busy), W'(0));
    Op = OP_MTLO; A = 32'hFFFFFFFF; Start = 1'b1;
    tick();
    Start = 1'b0;
    $display("mtlo a=ffffffff -> lo=%h hi=%h", LO, HI);
    chk("mtlo.lo", LO, 32'hFFFFFFFF);
    chk("mtlo.hi", HI, 32'h12345678);

`ifdef HILO_MADD_EN
    do_vec("maddu", OP_MADDU, 32'd2, 32'd3, 32'h12345679, 32'h00000005, 1'b0, -1);
    do_vec("msub", OP_MSUB, 32'hFFFFFFFF, 32'd1, 32'h12345679, 32'h00000006, 1'b0, -1);
`else
    Op = OP_MADDU; A = 32'd2; B = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("maddu_off.busy0", W'(Busy), W'(0));
    tick();
    $display("maddu (disabled) -> hi=%h lo=%h busy=%b done=%b", HI, LO, Busy, Done);
    chk("maddu_off.busy1", W'(Busy), W'(0));
    chk("maddu_off.done", W'(Done), W'(0));
    chk("maddu_off.hi", HI, 32'h12345678);
    chk("maddu_off.lo", LO, 32'hFFFFFFFF);
`endif

    Op = OP_DIVU; A = 32'd100; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    chk("clr.busy", W'(Busy), W'(0));
    chk("clr.hi", HI, '0);
    chk("clr.lo", LO, '0);
    done_seen = 1'b0;
    repeat (40) begin
      done_seen |= Done;
      tick();
    end
    $display("clr mid-DIV -> hi=%h lo=%h busy=%b done_seen=%b", HI, LO, Busy, done_seen);
    chk("clr.no_done", W'(done_seen), W'(0));

    do_vec("after_clr", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
